// File: rtl/comp_match_pkg.sv
// Shared constants for the compare-match timer: register map, field positions
// and the control state encoding.
package comp_match_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_SHADOW = 2'd3;

    localparam int CTRL_EN           = 0;
    localparam int CTRL_CONT         = 1;
    localparam int CTRL_IRQ_EN       = 2;
    localparam int CTRL_PRESCALE_LSB = 8;

    localparam int STAT_MATCH    = 0;
    localparam int STAT_RUN      = 1;
    localparam int STAT_MCNT_LSB = 16;
    localparam int MCNT_W        = 8;

    localparam logic [MCNT_W-1:0] MCNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic [MCNT_W-1:0] mcnt_inc(input logic [MCNT_W-1:0] v);
        return (v == MCNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmt_prescaler.sv
// Clock divider: one tick every div+1 cycles, held in reset while clear is high.
module cmt_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt;

    // >= rather than == so lowering div mid-period cannot strand the counter
    assign tick = !clear && (cnt >= div);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/comp_match_timer.sv
// Compare-match timer with Avalon-MM register slave: counts prescaled ticks up
// to a shadowed compare value, then restarts (CONT) or stops in HOLD.
module comp_match_timer
    import comp_match_pkg::*;
#(
    parameter int PRESCALE_W = 8,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] comp_data,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             match_pulse,
    output logic             irq
);

    state_e                  state, state_nxt;
    logic                    en, en_nxt;
    logic                    cont, cont_nxt;
    logic                    irq_en, irq_en_nxt;
    logic [PRESCALE_W-1:0]   prescale, prescale_nxt;
    logic                    match_flag, match_flag_nxt;
    logic [MCNT_W-1:0]       mcnt, mcnt_nxt;
    logic [CNT_W-1:0]        counter, counter_nxt;
    logic [CNT_W-1:0]        shadow, shadow_nxt;

    logic wr, wr_ctrl, wr_status, wr_count;
    logic tick, tick_eff, match;

    assign wr        = chipselect && !write_n;
    assign wr_ctrl   = wr && (address == ADDR_CTRL);
    assign wr_status = wr && (address == ADDR_STATUS);
    assign wr_count  = wr && (address == ADDR_COUNT);

    cmt_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != ST_RUN),
        .div     (prescale),
        .tick    (tick)
    );

    always_comb begin
        en_nxt         = en;
        cont_nxt       = cont;
        irq_en_nxt     = irq_en;
        prescale_nxt   = prescale;
        match_flag_nxt = match_flag;
        mcnt_nxt       = mcnt;
        counter_nxt    = counter;
        shadow_nxt     = shadow;
        state_nxt      = state;

        // a software COUNT write suppresses the tick entirely
        tick_eff = (state == ST_RUN) && tick && !wr_count;
        match    = tick_eff && (counter == shadow);

        if (wr_ctrl) begin
            en_nxt       = writedata[CTRL_EN];
            cont_nxt     = writedata[CTRL_CONT];
            irq_en_nxt   = writedata[CTRL_IRQ_EN];
            prescale_nxt = writedata[CTRL_PRESCALE_LSB +: PRESCALE_W];
        end
        if (match && !cont)
            en_nxt = 1'b0;

        if (wr_count)
            counter_nxt = CNT_W'(writedata);
        else if (match)
            counter_nxt = cont ? '0 : counter;
        else if (tick_eff)
            counter_nxt = counter + 1'b1;

        if (wr_status && writedata[STAT_MATCH])
            match_flag_nxt = 1'b0;
        if (wr_status && writedata[STAT_RUN])
            mcnt_nxt = '0;
        if (match) begin
            match_flag_nxt = 1'b1;
            mcnt_nxt       = mcnt_inc(mcnt_nxt);
        end

        if (state != ST_RUN || match)
            shadow_nxt = comp_data;

        unique case (state)
            ST_IDLE: if (en_nxt) state_nxt = ST_RUN;
            ST_RUN: begin
                if (match && !cont)
                    state_nxt = ST_HOLD;
                else if (!en_nxt)
                    state_nxt = ST_IDLE;
            end
            ST_HOLD: if (en_nxt) state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            en          <= 1'b0;
            cont        <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= '0;
            match_flag  <= 1'b0;
            mcnt        <= '0;
            counter     <= '0;
            shadow      <= '0;
            match_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            en          <= en_nxt;
            cont        <= cont_nxt;
            irq_en      <= irq_en_nxt;
            prescale    <= prescale_nxt;
            match_flag  <= match_flag_nxt;
            mcnt        <= mcnt_nxt;
            counter     <= counter_nxt;
            shadow      <= shadow_nxt;
            match_pulse <= match;
        end
    end

    assign irq = match_flag && irq_en;

    always_comb begin
        readdata = '0;
        unique case (address)
            ADDR_CTRL: begin
                readdata[CTRL_EN]                           = en;
                readdata[CTRL_CONT]                         = cont;
                readdata[CTRL_IRQ_EN]                       = irq_en;
                readdata[CTRL_PRESCALE_LSB +: PRESCALE_W]   = prescale;
            end
            ADDR_STATUS: begin
                readdata[STAT_MATCH]               = match_flag;
                readdata[STAT_RUN]                 = (state == ST_RUN);
                readdata[STAT_MCNT_LSB +: MCNT_W]  = mcnt;
            end
            ADDR_COUNT:  readdata = 32'(counter);
            ADDR_SHADOW: readdata = 32'(shadow);
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_comp_match_timer.sv
// Self-checking bench for comp_match_timer: directed scenarios plus random
// register traffic, compared every cycle against a behavioural model.
module tb_comp_match_timer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] comp_data = '0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        match_pulse;
    logic        irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    comp_match_timer #(.PRESCALE_W(8), .CNT_W(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .comp_data   (comp_data),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
        .match_pulse (match_pulse),
        .irq         (irq)
    );

    // behavioural model: mode 0 stopped, 1 counting, 2 halted after one-shot match
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2;
    int          m_mode, m_phase, m_presc, m_mcnt;
    bit          m_en, m_cont, m_irqen, m_flag, m_pulse;
    bit   [31:0] m_cnt, m_shadow;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r = {16'b0, m_presc[7:0], 5'b0, m_irqen, m_cont, m_en};
            2'd1: r = {8'b0, m_mcnt[7:0], 14'b0, (m_mode == M_RUN), m_flag};
            2'd2: r = m_cnt;
            default: r = m_shadow;
        endcase
        return r;
    endfunction

    task automatic m_reset();
        m_mode = M_IDLE; m_phase = 0; m_presc = 0; m_mcnt = 0;
        m_en = 0; m_cont = 0; m_irqen = 0; m_flag = 0; m_pulse = 0;
        m_cnt = '0; m_shadow = '0;
    endtask

    task automatic m_step();
        bit wr, wc, tk, te, mt, old_cont;
        int old_mode;
        wr = chipselect && !write_n;
        wc = wr && (address == 2'd2);
        tk = (m_mode == M_RUN) && (m_phase >= m_presc);
        te = tk && !wc;
        mt = te && (m_cnt == m_shadow);
        old_cont = m_cont;
        old_mode = m_mode;
        m_phase = (m_mode != M_RUN || tk) ? 0 : m_phase + 1;
        if (wc) m_cnt = writedata;
        else if (mt) begin if (old_cont) m_cnt = '0; end
        else if (te) m_cnt = 32'((64'(m_cnt) + 64'd1) % 64'h1_0000_0000);
        if (wr && address == 2'd0) begin
            m_en = writedata[0]; m_cont = writedata[1]; m_irqen = writedata[2];
            m_presc = int'(writedata[15:8]);
        end
        if (mt && !old_cont) m_en = 0;
        if (wr && address == 2'd1 && writedata[1]) m_mcnt = 0;
        if (wr && address == 2'd1 && writedata[0]) m_flag = 0;
        if (mt) begin
            m_flag = 1;
            m_mcnt = (m_mcnt >= 255) ? 255 : m_mcnt + 1;
        end
        if (old_mode != M_RUN || mt) m_shadow = comp_data;
        m_pulse = mt;
        if (old_mode == M_RUN) m_mode = (mt && !old_cont) ? M_HOLD : (m_en ? M_RUN : M_IDLE);
        else if (m_en) m_mode = M_RUN;
    endtask

    // one clock: compare outputs with the model, advance both across the edge
    task automatic cycle();
        #1;
        chk("readdata", readdata, m_read(address));
        chk("match_pulse", {31'b0, match_pulse}, {31'b0, m_pulse});
        chk("irq", {31'b0, irq}, {31'b0, m_flag & m_irqen});
        m_step();
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            address = 2'($urandom_range(0, 3));
            cycle();
        end
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        repeat (2) @(posedge clk);
        m_reset();
        #3 reset_n = 1'b1;
    endtask

    // counts edges after the call; records the edge index of the first two pulses
    task automatic track(input int n, input int chg_at, input logic [31:0] chg_val,
                         output int first, output int second, output int npulse);
        first = 0; second = 0; npulse = 0;
        for (int i = 1; i <= n; i++) begin
            if (i == chg_at) comp_data = chg_val;
            address = 2'($urandom_range(0, 3));
            cycle();
            if (match_pulse) begin
                npulse++;
                if (npulse == 1) first = i;
                else if (npulse == 2) second = i;
            end
        end
    endtask

    initial begin
        int f, s, np;
        logic [31:0] d;
        m_reset();
        #2;
        chk("rst_pulse", {31'b0, match_pulse}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1 chk("rst_reg", readdata, 32'd0);
        end
        do_reset();

        // continuous mode, period of 6 cycles
        comp_data = 32'd5; idle(2);
        wr_reg(2'd0, 32'h3);
        track(20, 0, '0, f, s, np);
        chk("cont_first", f, 6);
        chk("cont_second", s, 12);
        chk("cont_npulse", np, 3);
        rd_chk("cont_status", 2'd1, 32'h0003_0003);

        // one-shot with prescale 2
        do_reset();
        comp_data = 32'd3; idle(2);
        wr_reg(2'd0, 32'h201);
        track(30, 0, '0, f, s, np);
        chk("oneshot_first", f, 12);
        chk("oneshot_npulse", np, 1);
        rd_chk("oneshot_count", 2'd2, 32'd3);
        rd_chk("oneshot_ctrl", 2'd0, 32'h200);
        rd_chk("oneshot_status", 2'd1, 32'h0001_0001);

        // compare change mid-period only takes effect after the next match
        do_reset();
        comp_data = 32'd10; idle(2);
        wr_reg(2'd0, 32'h3);
        track(20, 5, 32'd4, f, s, np);
        chk("shadow_first", f, 11);
        chk("shadow_second", s, 16);

        // MATCH clear coinciding with a match loses
        do_reset();
        comp_data = 32'd5; idle(2);
        wr_reg(2'd0, 32'h7);
        idle(11);
        wr_reg(2'd1, 32'h1);
        chk("w1c_race_irq", {31'b0, irq}, 32'd1);
        rd_chk("w1c_race_status", 2'd1, 32'h0002_0003);
        idle(1);
        wr_reg(2'd1, 32'h1);
        chk("w1c_irq", {31'b0, irq}, 32'd0);

        // counter wrap and MCNT saturation
        do_reset();
        comp_data = 32'd1; idle(2);
        wr_reg(2'd2, 32'hFFFF_FFFE);
        rd_chk("wrap_load", 2'd2, 32'hFFFF_FFFE);
        wr_reg(2'd0, 32'h3);
        idle(2);
        rd_chk("wrap_zero", 2'd2, 32'd0);
        track(2, 0, '0, f, s, np);
        chk("wrap_match", f, 2);
        idle(700);
        address = 2'd1;
        #1 chk("mcnt_sat", {24'b0, readdata[23:16]}, 32'd255);

        // asynchronous reset mid-period
        do_reset();
        comp_data = 32'd20; idle(2);
        wr_reg(2'd0, 32'h3);
        idle(7);
        rd_chk("pre_rst_count", 2'd2, 32'd7);
        #1 reset_n = 1'b0;
        #1;
        chk("async_pulse", {31'b0, match_pulse}, 32'd0);
        chk("async_irq", {31'b0, irq}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1 chk("async_reg", readdata, 32'd0);
        end
        comp_data = 32'h55;
        m_reset();
        @(posedge clk);
        #3 reset_n = 1'b1;
        address = 2'd3;
        cycle();
        rd_chk("post_rst_shadow", 2'd3, 32'h55);

        // random register traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) comp_data = 32'($urandom_range(0, 12));
            address = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                case (address)
                    2'd0: d = {16'b0, 8'($urandom_range(0, 3)), 5'b0, 2'($urandom_range(0, 3)),
                               1'($urandom_range(0, 3) != 0)};
                    2'd1: d = 32'($urandom_range(0, 3));
                    2'd2: d = 32'($urandom_range(0, 12));
                    default: d = $urandom;
                endcase
                wr_reg(address, d);
            end else begin
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
